// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    localparam int DIV_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract, keep or restore.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    assign shifted = {rem_in, bit_in};
    assign q_bit   = (shifted >= {1'b0, divisor});
    // When the trial is non-negative the true difference is below the divisor,
    // so the low WIDTH bits of the modular subtraction are exact.
    assign diff    = shifted[WIDTH-1:0] - divisor;
    assign rem_out = q_bit ? diff : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_seq.sv
// Sequential unsigned divider: one restoring step per cycle, valid/ready on both sides.
module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] quot_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] divisor_reg;
    logic [CW-1:0]    step_reg;
    logic             dbz_reg;

    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic             accept;

    assign accept = in_valid && (state_reg == IDLE);

    // quot_reg doubles as the dividend shift register: its MSB feeds each step.
    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_reg),
        .bit_in  (quot_reg[WIDTH-1]),
        .divisor (divisor_reg),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (in_valid) state_next = (y == '0) ? DONE : RUN;
            RUN:  if (step_reg == LAST_STEP) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            quot_reg    <= '0;
            rem_reg     <= '0;
            divisor_reg <= '0;
            step_reg    <= '0;
            dbz_reg     <= 1'b0;
        end else if (accept) begin
            if (y == '0) begin
                quot_reg <= '1;
                rem_reg  <= x;
                dbz_reg  <= 1'b1;
            end else begin
                quot_reg    <= x;
                rem_reg     <= '0;
                divisor_reg <= y;
                step_reg    <= '0;
                dbz_reg     <= 1'b0;
            end
        end else if (state_reg == RUN) begin
            rem_reg  <= step_rem;
            quot_reg <= WIDTH'({quot_reg, step_q});
            step_reg <= step_reg + CW'(1);
        end
    end

    assign in_ready    = (state_reg == IDLE);
    assign out_valid   = (state_reg == DONE);
    assign quot        = quot_reg;
    assign rem         = rem_reg;
    assign div_by_zero = dbz_reg;

endmodule
